// File: rtl/load_unit.sv
// Load unit: issues one word read per load request, then aligns and extends the
// selected byte/half/word into rd_data. Illegal or misaligned requests and stalls abort via ERR.
module load_unit #(
   parameter int unsigned REG_LEN = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ld_req,
   input  logic [2:0]         ld_type,
   input  logic [REG_LEN-1:0] ld_addr,
   output logic               busy,
   output logic               mem_req,
   output logic [REG_LEN-1:0] mem_addr,
   input  logic               mem_gnt,
   input  logic               mem_rvalid,
   input  logic [REG_LEN-1:0] mem_rdata,
   output logic [REG_LEN-1:0] rd_data,
   output logic               rd_valid,
   output logic               ld_err
);

   typedef enum logic [2:0] {StIdle, StReq, StWait, StResp, StErr} state_e;

   localparam logic [2:0] LdB  = 3'b000;
   localparam logic [2:0] LdH  = 3'b001;
   localparam logic [2:0] LdW  = 3'b010;
   localparam logic [2:0] LdBu = 3'b100;
   localparam logic [2:0] LdHu = 3'b101;

   state_e             state_q, state_d;
   logic [2:0]         type_q, type_d;
   logic [1:0]         off_q, off_d;
   logic [REG_LEN-1:0] addr_q, addr_d;
   logic [REG_LEN-1:0] rd_data_q, rd_data_d;
   logic [7:0]         cnt_q, cnt_d;

   logic               type_ok;
   logic               aligned;
   logic               timeout_hit;
   logic [7:0]         byte_sel;
   logic [15:0]        half_sel;
   logic [REG_LEN-1:0] load_result;

   always_comb begin
      type_ok = 1'b0;
      aligned = 1'b1;
      case (ld_type)
         LdB, LdBu: type_ok = 1'b1;
         LdH, LdHu: begin
            type_ok = 1'b1;
            aligned = ~ld_addr[0];
         end
         LdW: begin
            type_ok = 1'b1;
            aligned = (ld_addr[1:0] == 2'b00);
         end
         default: type_ok = 1'b0;
      endcase
   end

   // Abort on the cycle whose increment would make the counter reach TIMEOUT.
   assign timeout_hit = ({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT);

   always_comb begin
      byte_sel = 8'h00;
      case (off_q)
         2'd0: byte_sel = mem_rdata[7:0];
         2'd1: byte_sel = mem_rdata[15:8];
         2'd2: byte_sel = mem_rdata[23:16];
         2'd3: byte_sel = mem_rdata[31:24];
         default: byte_sel = 8'h00;
      endcase
      half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (type_q)
         LdB:     load_result = {{(REG_LEN-8){byte_sel[7]}}, byte_sel};
         LdBu:    load_result = {{(REG_LEN-8){1'b0}}, byte_sel};
         LdH:     load_result = {{(REG_LEN-16){half_sel[15]}}, half_sel};
         LdHu:    load_result = {{(REG_LEN-16){1'b0}}, half_sel};
         default: load_result = mem_rdata;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      type_d    = type_q;
      off_d     = off_q;
      addr_d    = addr_q;
      rd_data_d = rd_data_q;
      cnt_d     = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (ld_req) begin
               if (type_ok && aligned) begin
                  state_d = StReq;
                  type_d  = ld_type;
                  off_d   = ld_addr[1:0];
                  addr_d  = {ld_addr[REG_LEN-1:2], 2'b00};
                  cnt_d   = 8'd0;
               end else begin
                  state_d = StErr;
               end
            end
         end
         StReq: begin
            cnt_d = cnt_q + 8'd1;
            if (mem_gnt) begin
               state_d = StWait;
            end else if (timeout_hit) begin
               state_d = StErr;
            end
         end
         StWait: begin
            cnt_d = cnt_q + 8'd1;
            if (mem_rvalid) begin
               rd_data_d = load_result;
               state_d   = StResp;
            end else if (timeout_hit) begin
               state_d = StErr;
            end
         end
         StResp:  state_d = StIdle;
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         type_q    <= 3'b000;
         off_q     <= 2'b00;
         addr_q    <= '0;
         rd_data_q <= '0;
         cnt_q     <= 8'd0;
      end else begin
         state_q   <= state_d;
         type_q    <= type_d;
         off_q     <= off_d;
         addr_q    <= addr_d;
         rd_data_q <= rd_data_d;
         cnt_q     <= cnt_d;
      end
   end

   assign busy     = (state_q != StIdle);
   assign mem_req  = (state_q == StReq);
   assign mem_addr = addr_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = (state_q == StResp);
   assign ld_err   = (state_q == StErr);

endmodule

// File: tb/tb_load_unit.sv
// Scoreboarded bench for load_unit: each request pushes its expected outcome, and a
// negedge monitor pops and compares whenever rd_valid or ld_err fires.
module tb_load_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ld_req = 1'b0;
   logic [2:0]  ld_type = 3'b000;
   logic [31:0] ld_addr = 32'h0;
   logic        busy, mem_req, rd_valid, ld_err;
   logic [31:0] mem_addr, rd_data;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   typedef struct packed {
      logic        is_err;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] model_rd = 32'h0;

   always #5 clk = ~clk;

   load_unit #(
      .REG_LEN(32),
      .TIMEOUT(8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ld_req    (ld_req),
      .ld_type   (ld_type),
      .ld_addr   (ld_addr),
      .busy      (busy),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_gnt   (mem_gnt),
      .mem_rvalid(mem_rvalid),
      .mem_rdata (mem_rdata),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .ld_err    (ld_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [31:0] a,
                                            input logic [31:0] d);
      logic [31:0] b, h;
      b = (d >> (a[1:0] * 5'd8)) & 32'h0000_00FF;
      h = (d >> (a[1] ? 16 : 0)) & 32'h0000_FFFF;
      case (t)
         3'b000:  return b[7] ? (b | 32'hFFFF_FF00) : b;
         3'b100:  return b;
         3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
         3'b101:  return h;
         default: return d;
      endcase
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && (rd_valid || ld_err)) begin
         if (sb.size() == 0) begin
            check("sb_unexpected", {30'd0, rd_valid, ld_err}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("sb_err", {31'd0, ld_err}, {31'd0, e.is_err});
            check("sb_valid", {31'd0, rd_valid}, {31'd0, ~e.is_err});
            check("sb_data", rd_data, e.data);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_mreq"}, {31'd0, mem_req}, 32'd0);
      check({tag, "_maddr"}, mem_addr, 32'd0);
      check({tag, "_rd"}, rd_data, 32'd0);
      check({tag, "_rvalid"}, {31'd0, rd_valid}, 32'd0);
      check({tag, "_err"}, {31'd0, ld_err}, 32'd0);
   endtask

   task automatic do_load(input logic [2:0] t, input logic [31:0] a, input int gnt_dly,
                          input logic [31:0] rdata);
      logic ok;
      ok = (t inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) &&
           !(((t == 3'b001) || (t == 3'b101)) && a[0]) &&
           !((t == 3'b010) && (a[1:0] != 2'b00));
      @(negedge clk);
      ld_req  = 1'b1;
      ld_type = t;
      ld_addr = a;
      if (!ok) begin
         sb.push_back('{1'b1, model_rd});
         @(negedge clk);
         ld_req = 1'b0;
         check("err_mreq", {31'd0, mem_req}, 32'd0);
         check("err_busy", {31'd0, busy}, 32'd1);
         check("err_pulse", {31'd0, ld_err}, 32'd1);
         @(negedge clk);
         check("err_done", {31'd0, ld_err}, 32'd0);
         check("err_idle", {31'd0, busy}, 32'd0);
         check("err_mreq2", {31'd0, mem_req}, 32'd0);
         check("err_rd_hold", rd_data, model_rd);
      end else begin
         model_rd = ref_load(t, a, rdata);
         sb.push_back('{1'b0, model_rd});
         @(negedge clk);
         // Requests and stray read data while busy must be dropped.
         ld_req     = 1'b1;
         ld_type    = 3'b011;
         mem_rvalid = 1'b1;
         mem_rdata  = 32'hDEAD_BEEF;
         for (int i = 0; i < gnt_dly; i++) begin
            check("req_held", {31'd0, mem_req}, 32'd1);
            check("req_addr", mem_addr, {a[31:2], 2'b00});
            @(negedge clk);
         end
         ld_req     = 1'b0;
         mem_rvalid = 1'b0;
         check("req_gnt", {31'd0, mem_req}, 32'd1);
         check("req_gnt_addr", mem_addr, {a[31:2], 2'b00});
         mem_gnt = 1'b1;
         @(negedge clk);
         mem_gnt = 1'b0;
         check("wait_mreq", {31'd0, mem_req}, 32'd0);
         check("wait_busy", {31'd0, busy}, 32'd1);
         mem_rvalid = 1'b1;
         mem_rdata  = rdata;
         @(negedge clk);
         mem_rvalid = 1'b0;
         check("resp_valid", {31'd0, rd_valid}, 32'd1);
         check("resp_data", rd_data, model_rd);
         @(negedge clk);
         check("post_busy", {31'd0, busy}, 32'd0);
         check("post_valid", {31'd0, rd_valid}, 32'd0);
      end
   endtask

   task automatic do_timeout();
      @(negedge clk);
      ld_req  = 1'b1;
      ld_type = 3'b010;
      ld_addr = 32'h40;
      sb.push_back('{1'b1, model_rd});
      @(negedge clk);
      ld_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("to_mreq", {31'd0, mem_req}, 32'd1);
         @(negedge clk);
      end
      check("to_err", {31'd0, ld_err}, 32'd1);
      check("to_drop", {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      check("to_busy", {31'd0, busy}, 32'd0);
      check("to_mreq_off", {31'd0, mem_req}, 32'd0);
      check("to_rd_hold", rd_data, model_rd);
   endtask

   task automatic do_reset_in_wait();
      @(negedge clk);
      ld_req  = 1'b1;
      ld_type = 3'b010;
      ld_addr = 32'h80;
      @(negedge clk);
      ld_req  = 1'b0;
      check("rw_req", {31'd0, mem_req}, 32'd1);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      check("rw_wait", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst        = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1234_5678;
      check_reset_outputs("rw_after");
      @(negedge clk);
      mem_rvalid = 1'b0;
      check_reset_outputs("rw_late");
      model_rd = 32'h0;
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      do_load(3'b000, 32'h0000_0103, 0, 32'h8011_2233);
      check("lb_value", rd_data, 32'hFFFF_FF80);
      do_load(3'b101, 32'h0000_0202, 4, 32'hBEEF_1234);
      check("lhu_value", rd_data, 32'h0000_BEEF);
      do_load(3'b010, 32'h0000_0001, 0, 32'h0);
      do_load(3'b011, 32'h0000_0010, 0, 32'h0);
      do_load(3'b010, 32'h0000_0010, 0, 32'hCAFE_F00D);
      check("lw_value", rd_data, 32'hCAFE_F00D);
      do_load(3'b100, 32'h0000_0101, 2, 32'hA5B6_C7D8);
      check("lbu_value", rd_data, 32'h0000_00C7);
      do_load(3'b001, 32'h0000_0203, 0, 32'h0);
      do_timeout();
      do_reset_in_wait();
      do_load(3'b001, 32'h0000_0006, 1, 32'h8001_7FFF);
      check("lh_value", rd_data, 32'hFFFF_8001);

      repeat (2) @(negedge clk);
      check("sb_drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter REG_LEN, default 32, SHALL set the data and address width.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum cycles spent in REQ+WAIT before abort; its legal range is 1..255.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset, synchronous and active-high.
REQ-005 ld_req  in  1  SHALL request a load; it is sampled only in IDLE.
REQ-006 ld_type  in  3  SHALL select the load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes are illegal.
REQ-007 ld_addr  in  REG_LEN  SHALL be the byte address of the load.
REQ-008 busy  out  1  SHALL be high in every state except IDLE.
REQ-009 mem_req  out  1  SHALL request a memory read.
REQ-010 mem_addr  out  REG_LEN  SHALL be the word-aligned address {ld_addr[REG_LEN-1:2], 2'b00}.
REQ-011 mem_gnt  in  1  SHALL be the memory acceptance of mem_req.
REQ-012 mem_rvalid  in  1  SHALL qualify mem_rdata.
REQ-013 mem_rdata  in  REG_LEN  SHALL carry the read word.
REQ-014 rd_data  out  REG_LEN  SHALL carry the aligned, extended load result.
REQ-015 rd_valid  out  1  SHALL pulse for one cycle when rd_data is updated.
REQ-016 ld_err  out  1  SHALL pulse for one cycle on a misaligned load, an illegal type, or a timeout.

Function
REQ-017 The FSM SHALL have the states IDLE, REQ, WAIT, RESP and ERR.
REQ-018 IDLE with ld_req=1 and a legal, aligned request SHALL latch ld_type, ld_addr[1:0] and the word address, then go to REQ.
REQ-019 IDLE with ld_req=1 and an illegal type or misalignment SHALL go to ERR without asserting mem_req. Misaligned means LH/LHU with addr[0]=1, or LW with addr[1:0]!=00.
REQ-020 ERR SHALL last one cycle with ld_err=1 and then return to IDLE; rd_data is unchanged.
REQ-021 REQ SHALL hold mem_req=1 with a stable mem_addr until mem_gnt=1; the same cycle then moves to WAIT.
REQ-022 WAIT SHALL hold mem_req=0; on mem_rvalid=1 it SHALL register the extracted result into rd_data and go to RESP.
REQ-023 RESP SHALL last one cycle with rd_valid=1 and then return to IDLE.
REQ-024 mem_rvalid in IDLE, REQ, RESP or ERR SHALL be ignored.
REQ-025 ld_req while busy=1 SHALL be ignored and not queued.
REQ-026 Minimum latency SHALL be 3 cycles from ld_req to rd_valid: mem_req at +1 with gnt at +1, rvalid at +2, rd_valid at +3.
REQ-027 A counter SHALL clear on entry to REQ and increment each cycle in REQ or WAIT.
REQ-028 When the counter reaches TIMEOUT with no exit, the FSM SHALL go to ERR and drop mem_req at that edge.
REQ-029 LB/LBU SHALL select byte mem_rdata[8*off+7:8*off], where off = latched addr[1:0]; LB sign-extends and LBU zero-extends to REG_LEN.
REQ-030 LH/LHU SHALL select mem_rdata[15:0] when addr[1]=0 and mem_rdata[31:16] when addr[1]=1; LH sign-extends and LHU zero-extends.
REQ-031 LW SHALL pass mem_rdata unchanged.
REQ-032 rd_data SHALL hold its value between successful loads.
REQ-033 rd_valid and ld_err SHALL never be high in the same cycle.

Reset
REQ-034 With rst=1 at an edge, the FSM SHALL go to IDLE and the counter and latched fields SHALL clear.
REQ-035 Reset values SHALL be: busy=0, mem_req=0, mem_addr=0, rd_data=0, rd_valid=0, ld_err=0.
REQ-036 Reset mid-operation SHALL abort the load with no rd_valid or ld_err; a late mem_rvalid after reset SHALL be ignored.
REQ-037 rst SHALL take priority over every other input.

Verification
REQ-038 The bench SHALL cover LB: addr=0x103, mem_rdata=0x80112233, gnt immediate -> mem_addr=0x100, rd_data=0xFFFFFF80, rd_valid 3 cycles after ld_req.
REQ-039 The bench SHALL cover LHU: addr=0x202, rdata=0xBEEF1234, gnt delayed 4 cycles -> mem_req held 5 cycles, rd_data=0x0000BEEF.
REQ-040 The bench SHALL cover LW misaligned: addr=0x001 -> mem_req never asserted, ld_err pulse 1 cycle after ld_req, rd_data unchanged.
REQ-041 The bench SHALL cover ld_type=011 -> ld_err pulse and no memory access; a following legal LW at 0x10 with rdata=0xCAFEF00D -> rd_data=0xCAFEF00D.
REQ-042 The bench SHALL cover timeout: TIMEOUT=8, gnt never asserted -> ld_err 8 cycles after mem_req rises, mem_req=0 thereafter, busy=0 next cycle.
REQ-043 The bench SHALL cover reset in WAIT, then mem_rvalid=1 -> no rd_valid, all outputs at reset values, and the next load completes normally.
